l0_skew_bank: RTL and testbench

- Parametrised input-staging buffer for the systolic MAC array.
- Holds `row` independent FIFO lanes of `bw`-bit words, all written in parallel from one `row*bw` vector.
- Drains lanes in one of three run-time modes:
  - ALL: every lane in parallel.
  - ROTATE: one lane per request, round-robin.
  - SKEW: diagonal wave, lane i popped i cycles after the request, feeding the array's staggered west edge directly.
- FIFO storage is internal, with per-lane pointers and counters; there is no external FIFO instance.

---
 rtl/l0_skew_bank.sv | 121 ++++++++++++
 tb/tb_l0_skew_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/l0_skew_bank.sv
// l0_skew_bank: row-lane input staging FIFO bank for the systolic MAC array.
// All lanes are written in parallel. They drain all at once (ALL), one lane per
// request in round-robin order (ROTATE), or as a diagonal wave (SKEW) that
// feeds the array's staggered west edge.
module l0_skew_bank #(
  parameter int unsigned row   = 8,
  parameter int unsigned bw    = 4,
  parameter int unsigned depth = 64,
  localparam int unsigned aw   = $clog2(depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [row*bw-1:0] in,
  input  logic              rd,
  input  logic [1:0]        mode,
  output logic [row*bw-1:0] out,
  output logic [row-1:0]    out_valid,
  output logic              o_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_underflow
);

  localparam logic [aw-1:0] PtrOne   = aw'(1);
  localparam logic [aw:0]   CntOne   = (aw + 1)'(1);
  localparam logic [aw:0]   CntDepth = (aw + 1)'(depth);

  logic [bw-1:0] mem_q    [row][depth];
  logic [aw-1:0] wr_ptr_q [row];
  logic [aw-1:0] rd_ptr_q [row];
  logic [aw:0]   cnt_q    [row];
  logic [row-1:0] rot_q;
  logic [row-2:0] sk_q;

  logic [row-1:0] full, empty;
  logic [row-1:0] pop_req, pop_en;
  logic [row-1:0] sk_ext;
  logic           wr_en, pop_underflow;

  // Per-lane flags from the pre-cycle counts, and the aggregate status outputs
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < row; i++) begin
      full[i]  = (cnt_q[i] == CntDepth);
      empty[i] = (cnt_q[i] == '0);
    end
    o_full  = |full;
    o_ready = ~|full;
    o_empty = &empty;
    wr_en   = wr && ~|full;
  end

  // Decode which lanes pop this cycle and whether an empty lane was targeted
  always_comb begin
    pop_req       = '0;
    pop_en        = '0;
    pop_underflow = 1'b0;
    // Lane 0 takes rd directly; lane i>=1 takes rd delayed by i cycles
    sk_ext        = {sk_q, rd};
    case (mode)
      2'd1:    pop_req = rd ? rot_q : '0;
      2'd2:    pop_req = sk_ext;
      default: pop_req = {row{rd}};
    endcase
    if (mode == 2'd1 || mode == 2'd2) begin
      pop_en        = pop_req & ~empty;
      pop_underflow = |(pop_req & empty);
    end else begin
      // ALL keeps lanes aligned: one empty lane blocks every lane
      pop_underflow = rd && |empty;
      pop_en        = pop_underflow ? '0 : pop_req;
    end
  end

  // Lane storage; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < row; i++) begin
        mem_q[i][wr_ptr_q[i]] <= in[bw*i +: bw];
      end
    end
  end

  // Pointers, counts, rotate/skew control and registered lane outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < row; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rot_q       <= {{(row - 1){1'b0}}, 1'b1};
      sk_q        <= '0;
      out         <= '0;
      out_valid   <= '0;
      o_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < row; i++) begin
        if (wr_en) wr_ptr_q[i] <= wr_ptr_q[i] + PtrOne;
        if (pop_en[i]) begin
          rd_ptr_q[i]       <= rd_ptr_q[i] + PtrOne;
          out[bw*i +: bw]   <= mem_q[i][rd_ptr_q[i]];
        end
        case ({wr_en, pop_en[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CntOne;
          2'b01:   cnt_q[i] <= cnt_q[i] - CntOne;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      // Rotation advances on every ROTATE request, even onto an empty lane
      if (rd && mode == 2'd1) rot_q <= {rot_q[row-2:0], rot_q[row-1]};
      // Always shifts so a wave in flight completes its timing after a mode change
      sk_q      <= sk_ext[row-2:0];
      out_valid <= pop_en;
      if (pop_underflow) o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l0_skew_bank.sv
// Self-checking bench for l0_skew_bank: a cycle table for ALL/ROTATE/SKEW,
// simultaneous wr+rd and reset mid-wave, plus a hand-written full/wrap sequence.
module tb_l0_skew_bank;

  logic        clk = 1'b0;
  logic        reset, wr, rd;
  logic [31:0] din;
  logic [1:0]  mode;
  logic [31:0] out;
  logic [7:0]  out_valid;
  logic        o_ready, o_full, o_empty, o_underflow;

  always #5 clk = ~clk;

  l0_skew_bank #(.row(8), .bw(4), .depth(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .in          (din),
    .rd          (rd),
    .mode        (mode),
    .out         (out),
    .out_valid   (out_valid),
    .o_ready     (o_ready),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_underflow (o_underflow)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic [1:0]  md;
    logic [7:0]  ev;
    logic [31:0] eo;
    logic        ee;
    logic        ef;
    logic        eu;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic w, input logic [31:0] d, input logic rr,
                     input logic [1:0] m, input logic [7:0] ev, input logic [31:0] eo,
                     input logic ee, input logic ef, input logic eu);
    vec_t v;
    v.rst = r; v.wr = w; v.din = d; v.rd = rr; v.md = m;
    v.ev = ev; v.eo = eo; v.ee = ee; v.ef = ef; v.eu = eu;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge
  task automatic step(input logic r, input logic w, input logic [31:0] d, input logic rr,
                      input logic [1:0] m);
    reset = r; wr = w; din = d; rd = rr; mode = m;
    @(posedge clk);
    #1;
  endtask

  // Full-test vector k: lane i nibble = (k+i) mod 15, never 0xF
  function automatic logic [31:0] vec(input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'((k + i) % 15);
    return r;
  endfunction

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; din = '0; mode = 2'd0;

    //   rst wr din           rd md    ev     eo            ee ef eu
    add(1, 0, 32'h0,        0, 2'd0, 8'h00, 32'h00000000, 1, 0, 0);
    // ALL
    add(0, 1, 32'h76543210, 0, 2'd0, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'hFEDCBA98, 0, 2'd0, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd0, 8'hFF, 32'h76543210, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd0, 8'hFF, 32'hFEDCBA98, 1, 0, 0);
    add(0, 0, 32'h0,        0, 2'd0, 8'h00, 32'hFEDCBA98, 1, 0, 0);
    // ROTATE
    add(0, 1, 32'h87654321, 0, 2'd1, 8'h00, 32'hFEDCBA98, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h01, 32'hFEDCBA91, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h02, 32'hFEDCBA21, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h04, 32'hFEDCB321, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h08, 32'hFEDC4321, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h10, 32'hFED54321, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h20, 32'hFE654321, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h40, 32'hF7654321, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h80, 32'h87654321, 1, 0, 0);
    add(0, 0, 32'h0,        1, 2'd1, 8'h00, 32'h87654321, 1, 0, 1);
    // SKEW
    add(1, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 1, 32'h11111111, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'h22222222, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'h33333333, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd2, 8'h01, 32'h00000001, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd2, 8'h03, 32'h00000012, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd2, 8'h07, 32'h00000123, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h0E, 32'h00001233, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h1C, 32'h00012333, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h38, 32'h00123333, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h70, 32'h01233333, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'hE0, 32'h12333333, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'hC0, 32'h23333333, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h80, 32'h33333333, 1, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h00, 32'h33333333, 1, 0, 0);
    // Simultaneous wr+rd on count=1 (ALL): count stays 1
    add(1, 0, 32'h0,        0, 2'd0, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 1, 32'h5A5A5A5A, 0, 2'd0, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'h6B6B6B6B, 1, 2'd0, 8'hFF, 32'h5A5A5A5A, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd0, 8'hFF, 32'h6B6B6B6B, 1, 0, 0);
    add(0, 0, 32'h0,        1, 2'd0, 8'h00, 32'h6B6B6B6B, 1, 0, 1);
    // Reset mid-SKEW wave
    add(1, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 1, 32'h11111111, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'h22222222, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 1, 32'h33333333, 0, 2'd2, 8'h00, 32'h00000000, 0, 0, 0);
    add(0, 0, 32'h0,        1, 2'd2, 8'h01, 32'h00000001, 0, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h02, 32'h00000011, 0, 0, 0);
    add(1, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);
    add(0, 0, 32'h0,        0, 2'd2, 8'h00, 32'h00000000, 1, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].wr, tbl[n].din, tbl[n].rd, tbl[n].md);
      chk("out_valid", n, 32'(out_valid), 32'(tbl[n].ev));
      chk("out", n, out, tbl[n].eo);
      chk("o_empty", n, 32'(o_empty), 32'(tbl[n].ee));
      chk("o_full", n, 32'(o_full), 32'(tbl[n].ef));
      chk("o_ready", n, 32'(o_ready), 32'(!tbl[n].ef));
      chk("o_underflow", n, 32'(o_underflow), 32'(tbl[n].eu));
    end

    // Full boundary with pointer wrap: offset pointers by 4 first
    step(1, 0, 32'h0, 0, 2'd0);
    for (int k = 0; k < 4; k++) step(0, 1, 32'h01234567, 0, 2'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 32'h0, 1, 2'd0);
    chk("pre_fill_empty", 0, 32'(o_empty), 32'd1);
    for (int k = 0; k < 64; k++) step(0, 1, vec(k), 0, 2'd0);
    chk("fill_full", 0, 32'(o_full), 32'd1);
    chk("fill_ready", 0, 32'(o_ready), 32'd0);
    chk("fill_empty", 0, 32'(o_empty), 32'd0);
    step(0, 1, 32'hFFFFFFFF, 0, 2'd0);
    chk("drop_full", 0, 32'(o_full), 32'd1);
    chk("drop_valid", 0, 32'(out_valid), 32'd0);
    for (int k = 0; k < 64; k++) begin
      step(0, 0, 32'h0, 1, 2'd0);
      chk("drain_valid", k, 32'(out_valid), 32'h000000FF);
      chk("drain_data", k, out, vec(k));
    end
    step(0, 0, 32'h0, 0, 2'd0);
    chk("drain_empty", 0, 32'(o_empty), 32'd1);
    chk("drain_full", 0, 32'(o_full), 32'd0);
    chk("drain_ready", 0, 32'(o_ready), 32'd1);
    chk("drain_underflow", 0, 32'(o_underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
